mu01_prog_loader: RTL
=====================

// Module: mu01_prog_loader
// PURPOSE
//  Upstream boot stage for the mu01 core: receives a program image as a byte
//  stream, assembles big-endian 16-bit words, writes them from address 0 into
//  the 4K x 16 program memory, checks a frame checksum, then asserts cpu_run.
//  cpu_run releases the core: the core's active-high reset is driven by ~cpu_run.
// PARAMETERS
//  AW    12      memory address width; capacity 2**AW words
//  DW    16      memory word width; two bytes per word, fixed
//  SYNC  8'hA5   frame start byte
// PORTS
//  clk          in   1   system clock, all state on rising edge
//  reset        in   1   asynchronous, active-low reset
//  in_valid     in   1   byte source has in_data valid
//  in_data      in   8   stream byte
//  in_ready     out  1   loader accepts byte; transfer = in_valid & in_ready
//  mem_we       out  1   program memory write strobe, one cycle per word
//  mem_addr     out  AW  write address
//  mem_wdata    out  DW  write data
//  busy         out  1   frame in progress (state LEN_HI..CSUM)
//  done         out  1   image loaded, checksum good
//  err          out  1   last frame rejected
//  cpu_run      out  1   core release; high only after a good frame
//  words_loaded out  AW+1 words written in the current/last frame
// BEHAVIOUR
//  Reset (reset=0, async): state IDLE; in_ready=0; all other outputs 0.
//  in_ready = reset & (state != DONE); combinational from state.
//  Frame: SYNC, LEN_HI, LEN_LO, then 2*LEN data bytes (high byte first),
//   then CSUM = 8-bit sum mod 256 of data bytes only (excludes SYNC/LEN).
//  States / transitions (only on accepted bytes; no transfer -> hold):
//   IDLE:    byte==SYNC -> LEN_HI, clear sum, words_loaded, err; else discard.
//   LEN_HI:  latch LEN[15:8] -> LEN_LO.
//   LEN_LO:  latch LEN[7:0]; LEN==0 or LEN>2**AW -> ERROR (no writes);
//            else -> DATA_HI, word addr = 0.
//   DATA_HI: latch high byte, add to sum -> DATA_LO.
//   DATA_LO: add to sum; next cycle mem_we=1, mem_addr=addr,
//            mem_wdata={hi,lo}, words_loaded+1; addr+1;
//            last word -> CSUM else -> DATA_HI.
//   CSUM:    byte==sum -> DONE; else -> ERROR.
//   DONE:    done=1, cpu_run=1 from cycle after CSUM accept; absorbing until reset.
//   ERROR:   err=1, cpu_run=0; in_ready=1; bytes discarded except SYNC,
//            which restarts as from IDLE (err clears on that SYNC).
//  Latency: mem_we exactly 1 cycle after low byte accepted; writes are
//   registered, never back-to-back (min 2 cycles apart); no write addr wrap
//   since LEN <= 2**AW. Last write always precedes cpu_run rise.
//  mem_addr/mem_wdata hold last values when mem_we=0.
//  Writes done before a checksum failure are not undone; err flags image bad.
//  busy=1 in LEN_HI, LEN_LO, DATA_HI, DATA_LO, CSUM.
//  Reset mid-frame: outputs drop to reset values at once; a pending write is
//   cancelled; next frame restarts at address 0.
// TESTING
//  1 A5 00 04 80 05 A0 04 1F FF 70 00 B7 -> writes 0:8005 1:A004 2:1FFF
//    3:7000; done=1, cpu_run=1, words_loaded=4, err=0.
//  2 Same frame with CSUM B8 -> 4 writes, err=1, cpu_run=0; then good frame
//    of test 1 -> err=0, done=1, cpu_run=1.
//  3 A5 00 00 -> err=1, no mem_we; A5 10 01 (LEN 0x1001) -> err=1, no mem_we.
//  4 Leading 00 FF 3C before A5, random in_valid gaps between bytes ->
//    identical result to test 1; garbage bytes produce no writes.
//  5 reset low after A5 00 04 80 05 A0 -> all outputs 0 async, no further
//    mem_we; after release, test 1 frame loads correctly from address 0.
//  6 After DONE, drive in_valid=1 with A5 ... -> in_ready=0, no writes,
//    cpu_run stays 1, words_loaded stays 4.

Source files
------------

// File: rtl/mu01_prog_loader.sv
// mu01 boot loader: framed byte stream -> 16-bit program memory writes.
// Releases the core with cpu_run once the frame checksum matches.
module mu01_prog_loader #(
  parameter int         AW   = 12,
  parameter int         DW   = 16,
  parameter logic [7:0] SYNC = 8'hA5
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          in_valid,
  input  logic [7:0]    in_data,
  output logic          in_ready,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic          cpu_run,
  output logic [AW:0]   words_loaded
);

  typedef enum logic [2:0] {
    IDLE, LEN_HI, LEN_LO, DATA_HI,
    DATA_LO, CSUM, DONE, ERROR
  } state_e;

  localparam logic [16:0] MAXLEN = 17'(2**AW);

  state_e        state_q, state_d;
  logic [7:0]    lenhi_q, lenhi_d;
  logic [15:0]   len_q, len_d;
  logic [7:0]    hi_q, hi_d;
  logic [7:0]    sum_q, sum_d;
  logic [AW:0]   words_q, words_d;
  logic          we_q, we_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d;

  logic        xfer;
  logic        is_sync;
  logic [15:0] len_full;
  logic        len_bad;
  logic        last_word;

  assign xfer      = in_valid & in_ready;
  assign is_sync   = in_data == SYNC;
  assign len_full  = {lenhi_q, in_data};
  assign len_bad   = (len_full == 16'd0) ||
                     ({1'b0, len_full} > MAXLEN);
  assign last_word = (16'(words_q) + 16'd1) == len_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      lenhi_q <= '0;
      len_q   <= '0;
      hi_q    <= '0;
      sum_q   <= '0;
      words_q <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      lenhi_q <= lenhi_d;
      len_q   <= len_d;
      hi_q    <= hi_d;
      sum_q   <= sum_d;
      words_q <= words_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (xfer) begin
      unique case (state_q)
        IDLE:    if (is_sync) state_d = LEN_HI;
        LEN_HI:  state_d = LEN_LO;
        LEN_LO:  state_d = len_bad ? ERROR : DATA_HI;
        DATA_HI: state_d = DATA_LO;
        DATA_LO: state_d = last_word ? CSUM : DATA_HI;
        CSUM:    state_d = (in_data == sum_q) ? DONE : ERROR;
        DONE:    state_d = DONE;
        ERROR:   if (is_sync) state_d = LEN_HI;
        default: state_d = IDLE;
      endcase
    end
  end

  // Datapath; the word counter doubles as the write address.
  always_comb begin
    lenhi_d = lenhi_q;
    len_d   = len_q;
    hi_d    = hi_q;
    sum_d   = sum_q;
    words_d = words_q;
    we_d    = 1'b0;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    if (xfer) begin
      unique case (state_q)
        IDLE, ERROR: begin
          if (is_sync) begin
            sum_d   = '0;
            words_d = '0;
          end
        end
        LEN_HI:  lenhi_d = in_data;
        LEN_LO:  len_d = len_full;
        DATA_HI: begin
          hi_d  = in_data;
          sum_d = sum_q + in_data;
        end
        DATA_LO: begin
          sum_d   = sum_q + in_data;
          we_d    = 1'b1;
          addr_d  = words_q[AW-1:0];
          wdata_d = {hi_q, in_data};
          words_d = words_q + 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    in_ready = reset & (state_q != DONE);
    busy     = 1'b0;
    done     = 1'b0;
    err      = 1'b0;
    unique case (1'b1)
      state_q == DONE:  done = 1'b1;
      state_q == ERROR: err  = 1'b1;
      state_q == IDLE:  ;
      default:          busy = 1'b1;
    endcase
    cpu_run = done;
  end

  assign mem_we       = we_q;
  assign mem_addr     = addr_q;
  assign mem_wdata    = wdata_q;
  assign words_loaded = words_q;

endmodule
